// File: rtl/vga_pkg.sv
// Shared constants for the Bayer ordered-dither pipeline: mode encodings and
// the 2x2 / 4x4 threshold matrices, plus a lookup helper.
package vga_pkg;

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_STATIC   = 2'b01;
    localparam logic [1:0] MODE_TEMPORAL = 2'b10;
    localparam logic [1:0] MODE_STATIC_B = 2'b11;  // behaves exactly like MODE_STATIC

    // Row-major 4x4 Bayer matrix, index = {row, col}
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // Row-major 2x2 Bayer matrix, index = {row, col}
    localparam logic [3:0] BAYER2 [4] = '{
        4'd0,  4'd8,
        4'd12, 4'd4
    };

    // Threshold lookup; for the 2x2 matrix only the low index bits matter
    function automatic logic [3:0] bayer_threshold(input logic [1:0] row,
                                                   input logic [1:0] col,
                                                   input logic       big);
        if (big)
            return BAYER4[{row, col}];
        else
            return BAYER2[{row[0], col[0]}];
    endfunction

endpackage

// File: rtl/vga_dither_channel.sv
// One colour channel of the ditherer: truncates to OUT_W bits and, unless in
// bypass, rounds up when the normalised fraction exceeds the threshold.
module vga_dither_channel
    import vga_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-1:0]  value,
    input  logic [3:0]       threshold,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] dithered
);

    localparam int D = IN_W - OUT_W;

    logic [OUT_W-1:0] upper;
    logic [3:0]       f4;

    assign upper = value[IN_W-1:D];

    // Fraction is brought to a 4-bit scale so it can be compared to the matrix
    generate
        if (D >= 4) begin : g_frac_wide
            assign f4 = value[D-1:D-4];
        end else begin : g_frac_narrow
            assign f4 = 4'(value[D-1:0]) << (4 - D);
        end
    endgenerate

    // Increment that holds at full scale instead of wrapping to zero
    function automatic logic [OUT_W-1:0] sat_inc(input logic [OUT_W-1:0] u,
                                                 input logic             bump);
        if (bump && (u != {OUT_W{1'b1}}))
            return u + 1'b1;
        else
            return u;
    endfunction

    // Select truncation (bypass) or threshold-driven round-up
    always_comb begin
        dithered = upper;
        if (mode != MODE_BYPASS)
            dithered = sat_inc(upper, f4 > threshold);
    end

endmodule

// File: rtl/vga_dither_bayer.sv
// Two-stage ordered-dither pipeline for a VGA pixel stream. Stage 1 captures
// the pixel, timing and screen-position threshold; stage 2 registers the
// dithered result. Position counters follow de/hsync/vsync.
module vga_dither_bayer
    import vga_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 4,
    parameter int MATRIX_LOG2 = 2
) (
    input  logic                      I_clk,
    input  logic                      I_reset_n,
    input  logic [1:0]                I_mode,
    input  logic                      I_hsync,
    input  logic                      I_vsync,
    input  logic                      I_de,
    input  logic [CHANNELS*IN_W-1:0]  I_pixel,
    output logic                      O_hsync,
    output logic                      O_vsync,
    output logic                      O_de,
    output logic [CHANNELS*OUT_W-1:0] O_pixel
);

    localparam int MW = MATRIX_LOG2;

    logic [MW-1:0] col;
    logic [MW-1:0] row;
    logic [1:0]    frame;
    logic [MW-1:0] row_idx;
    logic [MW-1:0] col_idx;
    logic          hs_rise;
    logic          vs_rise;
    logic [3:0]    threshold;

    logic                     hsync_p1;
    logic                     vsync_p1;
    logic                     de_p1;
    logic [CHANNELS*IN_W-1:0] pixel_p1;
    logic [3:0]               threshold_p1;
    logic [1:0]               mode_p1;

    logic [CHANNELS*OUT_W-1:0] dithered;

    // Stage-1 sync registers double as the previous-cycle sync for edge detect
    assign hs_rise = I_hsync & ~hsync_p1;
    assign vs_rise = I_vsync & ~vsync_p1;

    // Position counters: col follows de, row follows hsync, frame follows vsync
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            col   <= '0;
            row   <= '0;
            frame <= '0;
        end else begin
            if (hs_rise)
                col <= '0;
            else if (I_de)
                col <= col + 1'b1;

            if (vs_rise)
                row <= '0;
            else if (hs_rise)
                row <= row + 1'b1;

            if (vs_rise)
                frame <= frame + 1'b1;
        end
    end

    // Temporal mode shifts the matrix phase each frame via the low index bits
    always_comb begin
        row_idx = row;
        col_idx = col;
        if (I_mode == MODE_TEMPORAL) begin
            row_idx[0] = row[0] ^ frame[1];
            col_idx[0] = col[0] ^ frame[0];
        end
        threshold = bayer_threshold(2'(row_idx), 2'(col_idx), MW == 2);
    end

    // ---- stage 1: capture pixel, timing, mode and threshold ----
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            hsync_p1     <= 1'b0;
            vsync_p1     <= 1'b0;
            de_p1        <= 1'b0;
            pixel_p1     <= '0;
            threshold_p1 <= '0;
            mode_p1      <= MODE_BYPASS;
        end else begin
            hsync_p1     <= I_hsync;
            vsync_p1     <= I_vsync;
            de_p1        <= I_de;
            pixel_p1     <= I_pixel;
            threshold_p1 <= threshold;
            mode_p1      <= I_mode;
        end
    end

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            vga_dither_channel #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_channel (
                .value     (pixel_p1[(CHANNELS-1-c)*IN_W +: IN_W]),
                .threshold (threshold_p1),
                .mode      (mode_p1),
                .dithered  (dithered[(CHANNELS-1-c)*OUT_W +: OUT_W])
            );
        end
    endgenerate

    // ---- stage 2: register results, blank pixel outside active video ----
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            O_hsync <= 1'b0;
            O_vsync <= 1'b0;
            O_de    <= 1'b0;
            O_pixel <= '0;
        end else begin
            O_hsync <= hsync_p1;
            O_vsync <= vsync_p1;
            O_de    <= de_p1;
            O_pixel <= de_p1 ? dithered : '0;
        end
    end

endmodule

// File: tb/tb_vga_dither_bayer.sv
// Bench for vga_dither_bayer: directed scenarios followed by random traffic,
// every output cycle compared against a screen-position reference model.
module tb_vga_dither_bayer;

    localparam int CHANNELS    = 3;
    localparam int IN_W        = 8;
    localparam int OUT_W       = 4;
    localparam int MATRIX_LOG2 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        hs, vs, de;
    logic [23:0] pix;
    logic        o_hs, o_vs, o_de;
    logic [11:0] o_pix;

    always #5 clk = ~clk;

    vga_dither_bayer #(
        .CHANNELS    (CHANNELS),
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .MATRIX_LOG2 (MATRIX_LOG2)
    ) dut (
        .I_clk     (clk),
        .I_reset_n (rst_n),
        .I_mode    (mode),
        .I_hsync   (hs),
        .I_vsync   (vs),
        .I_de      (de),
        .I_pixel   (pix),
        .O_hsync   (o_hs),
        .O_vsync   (o_vs),
        .O_de      (o_de),
        .O_pixel   (o_pix)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] px;
    } exp_t;

    exp_t exp_prev;
    exp_t exp_cur;

    // Model screen position and previous sync levels
    int   m_row, m_col, m_frame;
    logic m_prev_hs, m_prev_vs;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic logic [11:0] ref_pixel(input logic [1:0] md, input logic [23:0] p, input int th);
        logic [11:0] r;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int x, up, f;
            x  = int'(p[(2-ch)*8 +: 8]);
            up = x / 16;
            f  = x % 16;
            if (md != 2'b00 && f > th && up < 15)
                up = up + 1;
            r[(2-ch)*4 +: 4] = up[3:0];
        end
        return r;
    endfunction

    task automatic check_px(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed hs/vs/de %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_row     = 0;
        m_col     = 0;
        m_frame   = 0;
        m_prev_hs = 1'b0;
        m_prev_vs = 1'b0;
        exp_prev  = '0;
    endtask

    // One clock of stimulus; afterwards the outputs reflect the previous sample
    task automatic step(input logic [1:0] md, input logic h, input logic v,
                        input logic d, input logic [23:0] p);
        int   r, c, th;
        logic hr, vr;
        @(negedge clk);
        mode = md; hs = h; vs = v; de = d; pix = p;
        @(posedge clk);
        r = m_row;
        c = m_col;
        if (md == 2'b10) begin
            r = r ^ ((m_frame >> 1) & 1);
            c = c ^ (m_frame & 1);
        end
        th         = bayer[r][c];
        exp_cur.hs = h;
        exp_cur.vs = v;
        exp_cur.de = d;
        exp_cur.px = d ? ref_pixel(md, p, th) : 12'h000;
        hr = h & ~m_prev_hs;
        vr = v & ~m_prev_vs;
        if (hr)      m_col = 0;
        else if (d)  m_col = (m_col + 1) % 4;
        if (vr)      m_row = 0;
        else if (hr) m_row = (m_row + 1) % 4;
        if (vr)      m_frame = (m_frame + 1) % 4;
        m_prev_hs = h;
        m_prev_vs = v;
        #1;
        check_px("model_pixel", o_pix, exp_prev.px);
        check_ctl("model_timing", {o_hs, o_vs, o_de}, {exp_prev.hs, exp_prev.vs, exp_prev.de});
        exp_prev = exp_cur;
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 2'b00;
        hs    = 1'b0;
        vs    = 1'b0;
        de    = 1'b0;
        pix   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_px("reset_pixel", o_pix, 12'h000);
        check_ctl("reset_timing", {o_hs, o_vs, o_de}, 3'b000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // vsync rise: frame 1, row 0, col 0; temporal pixels
        step(2'b00, 1'b0, 1'b1, 1'b0, 24'h0);
        step(2'b00, 1'b0, 1'b0, 1'b0, 24'h0);
        step(2'b10, 1'b0, 1'b0, 1'b1, 24'h888888);
        step(2'b10, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("temporal_f1_col0", o_pix, 12'h888);
        step(2'b10, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("temporal_f1_col1", o_pix, 12'h999);

        // Mid-line asynchronous reset
        @(negedge clk);
        rst_n = 1'b0;
        de    = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        #1;
        check_px("async_reset_pixel", o_pix, 12'h000);
        check_ctl("async_reset_timing", {o_hs, o_vs, o_de}, 3'b000);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // First pixel after reset, static mode at row 0
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("pipe_empty_after_reset", o_pix, 12'h000);
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("static_col0", o_pix, 12'h999);

        // Blanking for 3 cycles, column held
        step(2'b01, 1'b0, 1'b0, 1'b0, 24'h888888);
        check_px("static_col1", o_pix, 12'h888);
        step(2'b01, 1'b0, 1'b0, 1'b0, 24'h888888);
        check_px("blank_0", o_pix, 12'h000);
        step(2'b01, 1'b0, 1'b0, 1'b0, 24'h888888);
        check_px("blank_1", o_pix, 12'h000);
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("blank_2", o_pix, 12'h000);
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("resume_col2", o_pix, 12'h999);

        // hsync rise: row 1, col 0
        step(2'b01, 1'b1, 1'b0, 1'b0, 24'h0);
        check_px("resume_col3", o_pix, 12'h888);
        step(2'b01, 1'b0, 1'b0, 1'b0, 24'h0);
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("row1_col0", o_pix, 12'h888);

        // Simultaneous hsync and vsync rise: row 0, col 0, frame 1
        step(2'b01, 1'b1, 1'b1, 1'b0, 24'h0);
        check_px("row1_col1", o_pix, 12'h999);
        step(2'b01, 1'b0, 1'b0, 1'b0, 24'h0);
        step(2'b10, 1'b0, 1'b0, 1'b1, 24'h888888);
        step(2'b01, 1'b0, 1'b0, 1'b1, 24'h888888);
        check_px("dual_edge_frame1_col0", o_pix, 12'h888);

        // Saturation at every matrix position, then bypass truncation
        for (int i = 0; i < 4; i++) begin
            step(2'b01, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
            if (i > 0) check_px("saturate", o_pix, 12'hFFF);
        end
        step(2'b00, 1'b0, 1'b0, 1'b1, 24'h8F8F8F);
        check_px("saturate_last", o_pix, 12'hFFF);
        step(2'b00, 1'b0, 1'b0, 1'b1, 24'h8F8F8F);
        check_px("bypass_0", o_pix, 12'h888);
        step(2'b00, 1'b0, 1'b0, 1'b0, 24'h0);
        check_px("bypass_1", o_pix, 12'h888);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 47) == 0,
                 $urandom_range(0, 7) != 0,
                 24'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_dither_bayer.md
VGA_DITHER_BAYER -- requirements
Module: vga_dither_bayer

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of colour channels packed in the pixel bus.
REQ-002 SHALL have parameter IN_W, default 8, input bits per channel.
REQ-003 SHALL have parameter OUT_W, default 4, output bits per channel; legal range 1 <= IN_W-OUT_W <= 8.
REQ-004 SHALL have parameter MATRIX_LOG2, default 2, giving a 2x2 matrix (1) or a 4x4 matrix (2).
REQ-005 SHALL have port I_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port I_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port I_mode  in  2  00 bypass, 01 static ordered, 10 temporal, 11 treated as 01.
REQ-008 SHALL have ports I_hsync, I_vsync, I_de  in  1 each  timing and data-enable.
REQ-009 SHALL have port I_pixel  in  CHANNELS*IN_W  channel 0 in the MSBs.
REQ-010 SHALL have ports O_hsync, O_vsync, O_de  out  1 each  delayed timing.
REQ-011 SHALL have port O_pixel  out  CHANNELS*OUT_W  dithered pixel, same channel order.

Function
REQ-012 SHALL delay all outputs by exactly 2 cycles: stage 1 registers inputs and threshold, stage 2 registers results.
REQ-013 SHALL detect sync rising edges against the previous-cycle registered sync.
REQ-014 SHALL keep a column counter of MATRIX_LOG2 bits: +1 (wrap) per cycle with I_de=1, held when I_de=0, cleared on an hsync rising edge.
REQ-015 SHALL keep a row counter of MATRIX_LOG2 bits: +1 (wrap) on an hsync rising edge, cleared on a vsync rising edge.
REQ-016 SHALL keep a 2-bit frame counter: +1 (wrap) on a vsync rising edge.
REQ-017 SHALL give vsync priority when both edges occur in the same cycle: row=0, col=0, frame+1.
REQ-018 SHALL use a 4x4 matrix with rows {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}, and a 2x2 matrix with rows {0,8}, {12,4}.
REQ-019 SHALL, in temporal mode, index the matrix with row^frame[1] and col^frame[0] (upper index bits unmodified); in static mode with row and col.
REQ-020 SHALL per channel split x into upper = top OUT_W bits and frac = low D = IN_W-OUT_W bits.
REQ-021 SHALL normalise frac to 4 bits as f4 = frac[D-1:D-4] when D >= 4, else frac << (4-D).
REQ-022 SHALL output upper+1 when f4 > threshold and upper is not all-ones, else upper (saturating, never wraps).
REQ-023 SHALL output upper (truncation) in bypass mode.
REQ-024 SHALL drive O_pixel = 0 in any cycle whose delayed data-enable is 0.
REQ-025 SHALL allow I_mode to change at any time, taking effect on the pixel sampled in the same cycle.

Reset
REQ-026 SHALL, while I_reset_n=0, clear all counters, previous-sync registers, pipeline registers, O_pixel, O_hsync, O_vsync and O_de to 0.
REQ-027 SHALL resume after reset deassertion with the first output valid 2 cycles after the first sampled input.

Structure
REQ-028 SHALL place mode encodings and both threshold matrices as constants in a shared package vga_pkg.
REQ-029 SHALL instantiate one sub-module vga_dither_channel per channel (inputs: value, threshold, mode; output: dithered value), generated CHANNELS times.

Verification
REQ-030 SHALL cover reset: assert I_reset_n=0 mid-line -> all outputs 0 immediately; after release the first pixel emerges 2 cycles later.
REQ-031 SHALL cover static mode: mode 01, I_pixel=0x888888, I_de=1 at row0 -> O_pixel 0x999 at col0 and 0x888 at col1.
REQ-032 SHALL cover saturation and bypass: 0xFFFFFF mode 01 -> 0xFFF at every position; 0x8F8F8F mode 00 -> 0x888.
REQ-033 SHALL cover counters: hsync rise -> col=0 and row+1; simultaneous hsync and vsync rise -> row=0, col=0, frame+1.
REQ-034 SHALL cover temporal mode: mode 10, frame=1, row0 col0, input 0x888888 -> threshold 8, O_pixel 0x888.
REQ-035 SHALL cover blanking: I_de=0 for 3 cycles -> O_pixel 0 and col held; col resumes from the held value.
